// File: rtl/qam_demap_pkg.sv
// Shared constants and FSM state type for the 16-QAM demapper scheduler.
package qam_demap_pkg;

    localparam int IN_W  = 22;
    localparam int OUT_W = 13;

    localparam logic signed [IN_W-1:0]  MID     = 22'sd323;
    localparam logic signed [IN_W-1:0]  ZERO_IN = 22'sd0;
    localparam logic signed [OUT_W-1:0] L       = 13'sd485;
    localparam logic signed [OUT_W-1:0] S       = 13'sd161;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/qam16_slicer.sv
// Combinational 16-QAM hard slicer: full-width signed decision, Gray-coded bits
// and reconstructed constellation point.
module qam16_slicer
    import qam_demap_pkg::*;
(
    input  logic signed [IN_W-1:0]  re_i,
    input  logic signed [IN_W-1:0]  im_i,
    output logic        [3:0]       bits_o,
    output logic signed [OUT_W-1:0] re_o,
    output logic signed [OUT_W-1:0] im_o
);

    always_comb begin
        bits_o = '0;
        re_o   = '0;
        im_o   = '0;

        if (re_i <= -MID) begin
            bits_o[3:2] = 2'b00;
            re_o        = -L;
        end else if (re_i <= ZERO_IN) begin
            bits_o[3:2] = 2'b01;
            re_o        = -S;
        end else if (re_i <= MID) begin
            bits_o[3:2] = 2'b11;
            re_o        = S;
        end else begin
            bits_o[3:2] = 2'b10;
            re_o        = L;
        end

        // Imaginary axis is mirrored: the top row carries code 00.
        if (im_i >= MID) begin
            bits_o[1:0] = 2'b00;
            im_o        = L;
        end else if (im_i >= ZERO_IN) begin
            bits_o[1:0] = 2'b01;
            im_o        = S;
        end else if (im_i >= -MID) begin
            bits_o[1:0] = 2'b11;
            im_o        = -S;
        end else begin
            bits_o[1:0] = 2'b10;
            im_o        = -L;
        end
    end

endmodule

// File: rtl/qam_demap_sched.sv
// Round-robin scheduler of two equalizer streams onto one shared 16-QAM slicer.
// Optional EVM accumulator enabled by macro QAM_DEMAP_EVM_EN.
module qam_demap_sched
    import qam_demap_pkg::*;
#(
    parameter int N_SC  = 64,
    parameter int IDX_W = $clog2(N_SC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              s_valid,
    output logic [1:0]              s_ready,
    input  logic signed [IN_W-1:0]  s0_re,
    input  logic signed [IN_W-1:0]  s0_im,
    input  logic signed [IN_W-1:0]  s1_re,
    input  logic signed [IN_W-1:0]  s1_im,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [3:0]              m_bits,
    output logic signed [OUT_W-1:0] m_re,
    output logic signed [OUT_W-1:0] m_im,
    output logic                    m_stream,
    output logic [IDX_W-1:0]        m_idx,
    output logic                    busy,
`ifdef QAM_DEMAP_EVM_EN
    output logic [31:0]             evm_sum,
    output logic                    evm_valid,
`endif
    output logic                    frame_done
);

    localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(N_SC);
    localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

    state_t                  state_q, state_d;
    logic [1:0][IDX_W:0]     cnt_q, cnt_d;
    logic                    rr_q, rr_d;
    logic                    m_valid_q, m_valid_d;
    logic [3:0]              m_bits_q, m_bits_d;
    logic signed [OUT_W-1:0] m_re_q, m_re_d;
    logic signed [OUT_W-1:0] m_im_q, m_im_d;
    logic                    m_stream_q, m_stream_d;
    logic [IDX_W-1:0]        m_idx_q, m_idx_d;

    logic [1:0]              elig;
    logic                    slot_free;
    logic                    gnt_vld;
    logic                    gnt_sel;
    logic signed [IN_W-1:0]  sl_re, sl_im;
    logic [3:0]              q_bits;
    logic signed [OUT_W-1:0] q_re, q_im;

    // Grant decision; ready is a function of valid, never the reverse.
    always_comb begin
        elig      = '0;
        gnt_vld   = 1'b0;
        gnt_sel   = rr_q;
        slot_free = !m_valid_q || m_ready;
        if (state_q == RUN) begin
            elig[0] = s_valid[0] && (cnt_q[0] < CNT_MAX);
            elig[1] = s_valid[1] && (cnt_q[1] < CNT_MAX);
        end
        if (slot_free) begin
            if (elig == 2'b11) begin
                gnt_vld = 1'b1;
                gnt_sel = rr_q;
            end else if (elig[0]) begin
                gnt_vld = 1'b1;
                gnt_sel = 1'b0;
            end else if (elig[1]) begin
                gnt_vld = 1'b1;
                gnt_sel = 1'b1;
            end
        end
    end

    assign s_ready = !gnt_vld ? 2'b00 : (gnt_sel ? 2'b10 : 2'b01);
    assign sl_re   = gnt_sel ? s1_re : s0_re;
    assign sl_im   = gnt_sel ? s1_im : s0_im;

    qam16_slicer u_slicer (
        .re_i   (sl_re),
        .im_i   (sl_im),
        .bits_o (q_bits),
        .re_o   (q_re),
        .im_o   (q_im)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        m_valid_d  = m_valid_q;
        m_bits_d   = m_bits_q;
        m_re_d     = m_re_q;
        m_im_d     = m_im_q;
        m_stream_d = m_stream_q;
        m_idx_d    = m_idx_q;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    rr_d    = 1'b0;
                end
            end
            RUN: begin
                if (cnt_q[0] == CNT_MAX && cnt_q[1] == CNT_MAX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!m_valid_q) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (m_ready) begin
            m_valid_d = 1'b0;
        end
        if (gnt_vld) begin
            m_valid_d      = 1'b1;
            m_bits_d       = q_bits;
            m_re_d         = q_re;
            m_im_d         = q_im;
            m_stream_d     = gnt_sel;
            m_idx_d        = cnt_q[gnt_sel][IDX_W-1:0];
            cnt_d[gnt_sel] = cnt_q[gnt_sel] + CNT_ONE;
            if (elig == 2'b11) begin
                rr_d = ~rr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rr_q       <= 1'b0;
            m_valid_q  <= 1'b0;
            m_bits_q   <= '0;
            m_re_q     <= '0;
            m_im_q     <= '0;
            m_stream_q <= 1'b0;
            m_idx_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            m_valid_q  <= m_valid_d;
            m_bits_q   <= m_bits_d;
            m_re_q     <= m_re_d;
            m_im_q     <= m_im_d;
            m_stream_q <= m_stream_d;
            m_idx_q    <= m_idx_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_bits   = m_bits_q;
    assign m_re     = m_re_q;
    assign m_im     = m_im_q;
    assign m_stream = m_stream_q;
    assign m_idx    = m_idx_q;
    assign busy     = (state_q == RUN) || (state_q == DRAIN);

`ifdef QAM_DEMAP_EVM_EN
    logic [31:0]          evm_q, evm_d;
    logic signed [IN_W:0] d_re, d_im;
    logic [IN_W:0]        a_re, a_im;

    // Error measured in the 22-bit input domain against the sign-extended decision.
    always_comb begin
        d_re  = {sl_re[IN_W-1], sl_re} - {{(IN_W+1-OUT_W){q_re[OUT_W-1]}}, q_re};
        d_im  = {sl_im[IN_W-1], sl_im} - {{(IN_W+1-OUT_W){q_im[OUT_W-1]}}, q_im};
        a_re  = d_re[IN_W] ? $unsigned(-d_re) : $unsigned(d_re);
        a_im  = d_im[IN_W] ? $unsigned(-d_im) : $unsigned(d_im);
        evm_d = evm_q;
        if (state_q == IDLE && start) begin
            evm_d = '0;
        end else if (gnt_vld) begin
            evm_d = evm_q + 32'(a_re) + 32'(a_im);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evm_q <= '0;
        end else begin
            evm_q <= evm_d;
        end
    end

    assign evm_sum   = evm_q;
    assign evm_valid = frame_done;
`endif

endmodule

// File: tb/tb_qam_demap_sched.sv
// Self-checking bench for qam_demap_sched: scoreboard of accepted symbols against
// a table-based 16-QAM decision model, plus scenario checks.
module tb_qam_demap_sched;

    localparam int N_SC  = 64;
    localparam int IDX_W = 6;
    localparam int LV [4] = '{-485, -161, 161, 485};
    localparam logic [1:0] GRAY [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [1:0]         s_valid = '0;
    logic [1:0]         s_ready;
    logic signed [21:0] s0_re = '0, s0_im = '0, s1_re = '0, s1_im = '0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [3:0]         m_bits;
    logic signed [12:0] m_re, m_im;
    logic               m_stream;
    logic [IDX_W-1:0]   m_idx;
    logic               busy, frame_done;
`ifdef QAM_DEMAP_EVM_EN
    logic [31:0]        evm_sum;
    logic               evm_valid;
`endif

    always #5 clk = ~clk;

    qam_demap_sched #(.N_SC(N_SC), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s0_re      (s0_re),
        .s0_im      (s0_im),
        .s1_re      (s1_re),
        .s1_im      (s1_im),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_bits     (m_bits),
        .m_re       (m_re),
        .m_im       (m_im),
        .m_stream   (m_stream),
        .m_idx      (m_idx),
        .busy       (busy),
`ifdef QAM_DEMAP_EVM_EN
        .evm_sum    (evm_sum),
        .evm_valid  (evm_valid),
`endif
        .frame_done (frame_done)
    );

    typedef struct { int stream; int idx; int re; int im; } exp_t;
    typedef struct { int stream; int idx; int bits; int re; int im; int cyc; } obs_t;

    exp_t  expq[$];
    obs_t  outlog[$];
    int    dir_re[$], dir_im[$];
    int    total = 0, bad = 0;
    int    fcyc = 0, out_cnt = 0, fd_cnt = 0;
    int    cnt [2];
    int    vmode [2];
    bit    take [2];
    int    rmode = 0, bp_lo = 40;
    bit    bp_seen_valid;
    bit    hold_pending = 0;
    logic [3:0]         h_bits;
    logic signed [12:0] h_re, h_im;
    logic               h_stream;
    logic [IDX_W-1:0]   h_idx;
    longint evm_exp;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Decision regions numbered from most negative to most positive level.
    function automatic void ref_slice(input int re, input int im, output logic [3:0] bits,
                                      output int ore, output int oim);
        int qr, qi;
        qr = (re <= -323) ? 0 : (re <= 0) ? 1 : (re <= 323) ? 2 : 3;
        qi = (im < -323) ? 0 : (im < 0) ? 1 : (im < 323) ? 2 : 3;
        ore  = LV[qr];
        oim  = LV[qi];
        bits = {GRAY[qr], GRAY[3 - qi]};
    endfunction

    function automatic int rand_pt();
        int unsigned r;
        int edges [9] = '{-323, -324, 323, 324, 0, -1, 1, -322, 322};
        r = $urandom_range(0, 9);
        if (r == 0) return edges[$urandom_range(0, 8)];
        if (r == 1) return ($urandom_range(0, 1) != 0) ? 2097151 : -2097152;
        return int'($urandom_range(0, 1400)) - 700;
    endfunction

    task automatic load_next(input int i);
        int re, im;
        if (i == 0 && dir_re.size() > 0) begin
            re = dir_re.pop_front();
            im = dir_im.pop_front();
        end else begin
            re = rand_pt();
            im = rand_pt();
        end
        if (i == 0) begin
            s0_re = 22'(re);
            s0_im = 22'(im);
        end else begin
            s1_re = 22'(re);
            s1_im = 22'(im);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, advance to next falling edge.
    task automatic cycle();
        logic [1:0] acc;
        exp_t e;
        logic [3:0] eb;
        int er, ei, dre, dim;
        for (int i = 0; i < 2; i++) begin
            if (take[i]) load_next(i);
            take[i] = 1'b0;
            case (vmode[i])
                0:       s_valid[i] = 1'b0;
                1:       s_valid[i] = 1'b1;
                2:       s_valid[i] = ($urandom_range(0, 3) != 0);
                default: s_valid[i] = (cnt[0] == N_SC);
            endcase
        end
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 2) != 0);
            default: m_ready = !(fcyc >= bp_lo && fcyc < bp_lo + 5);
        endcase
        #1;
        if (rmode == 2 && fcyc == bp_lo) bp_seen_valid = m_valid;
        acc = s_valid & s_ready;

        total++;
        if ((s_ready & ~s_valid) != 2'b00 || s_ready === 2'b11 || $isunknown(s_ready)) begin
            bad++;
            $display("FAIL s_ready_legal: s_ready=%b s_valid=%b required one-hot-or-zero subset of valid",
                     s_ready, s_valid);
        end

        if (hold_pending) begin
            total++;
            if (m_valid !== 1'b1 || m_bits !== h_bits || m_re !== h_re || m_im !== h_im ||
                m_stream !== h_stream || m_idx !== h_idx) begin
                bad++;
                $display("FAIL m_hold: v=%b bits=%b re=%0d im=%0d st=%b idx=%0d required v=1 bits=%b re=%0d im=%0d st=%b idx=%0d",
                         m_valid, m_bits, m_re, m_im, m_stream, m_idx, h_bits, h_re, h_im, h_stream, h_idx);
            end
        end

        if (m_valid === 1'b1 && !m_ready) begin
            hold_pending = 1'b1;
            h_bits = m_bits; h_re = m_re; h_im = m_im; h_stream = m_stream; h_idx = m_idx;
            total++;
            if (s_ready !== 2'b00) begin
                bad++;
                $display("FAIL ready_when_full: s_ready=%b required 00", s_ready);
            end
        end else begin
            hold_pending = 1'b0;
        end

        if (m_valid === 1'b1 && m_ready) begin
            out_cnt++;
            outlog.push_back('{int'(m_stream), int'(m_idx), int'(m_bits), int'(m_re), int'(m_im), fcyc});
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: stream=%b idx=%0d required no output", m_stream, m_idx);
            end else begin
                e = expq.pop_front();
                ref_slice(e.re, e.im, eb, er, ei);
                dre = e.re - er;
                dim = e.im - ei;
                evm_exp += iabs(dre) + iabs(dim);
                if (m_stream !== 1'(e.stream) || m_idx !== IDX_W'(e.idx) || m_bits !== eb ||
                    m_re !== 13'(er) || m_im !== 13'(ei)) begin
                    bad++;
                    $display("FAIL m_out: st=%b idx=%0d bits=%b re=%0d im=%0d required st=%0d idx=%0d bits=%b re=%0d im=%0d (in %0d,%0d)",
                             m_stream, m_idx, m_bits, m_re, m_im, e.stream, e.idx, eb, er, ei, e.re, e.im);
                end
            end
        end

        if (frame_done === 1'b1) begin
            fd_cnt++;
`ifdef QAM_DEMAP_EVM_EN
            total++;
            if (evm_valid !== 1'b1 || evm_sum !== 32'(evm_exp)) begin
                bad++;
                $display("FAIL evm_frame: valid=%b sum=%0d required valid=1 sum=%0d", evm_valid, evm_sum, evm_exp);
            end
`endif
        end

        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                total++;
                if (cnt[i] >= N_SC) begin
                    bad++;
                    $display("FAIL over_accept: stream=%0d count=%0d required below %0d", i, cnt[i], N_SC);
                end
                expq.push_back('{i, cnt[i], (i == 0) ? int'(s0_re) : int'(s1_re),
                                 (i == 0) ? int'(s0_im) : int'(s1_im)});
                cnt[i]++;
                take[i] = 1'b1;
            end
        end

        @(posedge clk);
        @(negedge clk);
        fcyc++;
    endtask

    task automatic frame_init();
        cnt[0] = 0; cnt[1] = 0;
        out_cnt = 0; fd_cnt = 0; fcyc = 0; evm_exp = 0;
        outlog.delete();
        take[0] = 1'b1; take[1] = 1'b1;
    endtask

    task automatic run_frame();
        int n;
        frame_init();
        start = 1'b1;
        cycle();
        start = 1'b0;
`ifdef QAM_DEMAP_EVM_EN
        total++;
        if (evm_sum !== 32'd0) begin
            bad++;
            $display("FAIL evm_clear: sum=%0d required 0", evm_sum);
        end
`endif
        n = 0;
        while (fd_cnt == 0 && n < 2000) begin
            cycle();
            n++;
        end
        total++;
        if (fd_cnt == 0) begin
            bad++;
            $display("FAIL frame_timeout: frame_done=0 after %0d cycles required 1", n);
        end
        repeat (3) cycle();
        total++;
        if (out_cnt != 2 * N_SC || fd_cnt != 1 || expq.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_totals: outputs=%0d done=%0d pending=%0d busy=%b required %0d 1 0 0",
                     out_cnt, fd_cnt, expq.size(), busy, 2 * N_SC);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; s_valid = 2'b11; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (m_valid !== 1'b0 || s_ready !== 2'b00 || busy !== 1'b0 || frame_done !== 1'b0 ||
            m_bits !== 4'd0 || m_re !== 13'sd0 || m_im !== 13'sd0 || m_stream !== 1'b0 || m_idx !== '0) begin
            bad++;
            $display("FAIL reset_outputs: v=%b rdy=%b busy=%b done=%b bits=%b required all zero",
                     m_valid, s_ready, busy, frame_done, m_bits);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (s_ready !== 2'b00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_ready: s_ready=%b busy=%b required 00 0", s_ready, busy);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL start_busy: busy=%b required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || s_ready !== 2'b00 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: busy=%b s_ready=%b m_valid=%b required 0 00 0", busy, s_ready, m_valid);
        end
        s_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_slicing();
        int in_re [4] = '{-400, 100, 323, 324};
        int in_im [4] = '{400, -100, -323, 0};
        logic [3:0] x_bits [4] = '{4'b0000, 4'b1111, 4'b1111, 4'b1001};
        int x_re [4] = '{-485, 161, 161, 485};
        int x_im [4] = '{485, -161, -161, 161};
        for (int k = 0; k < 4; k++) begin
            dir_re.push_back(in_re[k]);
            dir_im.push_back(in_im[k]);
        end
        vmode[0] = 1; vmode[1] = 2; rmode = 1;
        run_frame();
        foreach (outlog[j]) begin
            if (outlog[j].stream == 0 && outlog[j].idx < 4) begin
                int k;
                k = outlog[j].idx;
                total++;
                if (outlog[j].bits != int'(x_bits[k]) || outlog[j].re != x_re[k] || outlog[j].im != x_im[k]) begin
                    bad++;
                    $display("FAIL slice_point%0d: bits=%b re=%0d im=%0d required bits=%b re=%0d im=%0d",
                             k, 4'(outlog[j].bits), outlog[j].re, outlog[j].im, x_bits[k], x_re[k], x_im[k]);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int errs;
        vmode[0] = 1; vmode[1] = 1; rmode = 0;
        run_frame();
        errs = 0;
        foreach (outlog[j]) if (outlog[j].stream != (j % 2)) errs++;
        total++;
        if (errs != 0 || outlog.size() != 2 * N_SC) begin
            bad++;
            $display("FAIL fairness_alternate: out_of_order=%0d outputs=%0d required 0 and %0d",
                     errs, outlog.size(), 2 * N_SC);
        end
    endtask

    task automatic test_backpressure();
        vmode[0] = 1; vmode[1] = 1; rmode = 2; bp_lo = 40; bp_seen_valid = 1'b0;
        run_frame();
        total++;
        if (bp_seen_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_slot_full: m_valid at stall start=%b required 1", bp_seen_valid);
        end
    endtask

    task automatic test_uneven();
        int errs;
        vmode[0] = 1; vmode[1] = 3; rmode = 0;
        run_frame();
        errs = 0;
        foreach (outlog[j]) begin
            if (j < N_SC) begin
                if (outlog[j].stream != 0 || outlog[j].idx != j) errs++;
                if (j > 0 && outlog[j].cyc != outlog[j-1].cyc + 1) errs++;
            end else if (outlog[j].stream != 1 || outlog[j].idx != j - N_SC) begin
                errs++;
            end
        end
        total++;
        if (errs != 0 || outlog.size() != 2 * N_SC) begin
            bad++;
            $display("FAIL uneven_order: errors=%0d outputs=%0d required 0 and %0d", errs, outlog.size(), 2 * N_SC);
        end
    endtask

    task automatic test_random();
        vmode[0] = 2; vmode[1] = 2; rmode = 1;
        repeat (2) run_frame();
    endtask

    task automatic test_reset_mid();
        int n;
        vmode[0] = 1; vmode[1] = 1; rmode = 0;
        frame_init();
        start = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (out_cnt < 30 && n < 500) begin
            cycle();
            n++;
        end
        total++;
        if (out_cnt != 30) begin
            bad++;
            $display("FAIL mid_progress: outputs=%0d required 30", out_cnt);
        end
        rst_n = 1'b0;
        hold_pending = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || m_idx !== '0) begin
            bad++;
            $display("FAIL mid_reset_state: busy=%b m_valid=%b idx=%0d required 0 0 0", busy, m_valid, m_idx);
        end
        repeat (2) cycle();
        rst_n = 1'b1;
        expq.delete();
        total++;
        if (fd_cnt != 0) begin
            bad++;
            $display("FAIL mid_no_done: frame_done pulses=%0d required 0", fd_cnt);
        end
        run_frame();
        total++;
        if (outlog.size() == 0 || outlog[0].idx != 0 || outlog[0].stream != 0) begin
            bad++;
            $display("FAIL restart_idx: first output stream=%0d idx=%0d required 0 0",
                     (outlog.size() > 0) ? outlog[0].stream : -1, (outlog.size() > 0) ? outlog[0].idx : -1);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        vmode[0] = 0; vmode[1] = 0;
        take[0] = 1'b0; take[1] = 1'b0;
        cnt[0] = 0; cnt[1] = 0;
        test_reset();
        test_slicing();
        test_fairness();
        test_backpressure();
        test_uneven();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
